io_timer_irq: RTL and testbench

//  IO-bus responder: programmable 16-bit down-counter timer with interrupt output, on the core's 8-bit port bus.

---
 rtl/io_timer_pkg.sv | 17 +
 rtl/io_timer_if.sv | 9 +
 rtl/io_timer_presc.sv | 29 ++
 rtl/io_timer_irq.sv | 126 ++++++++++++
 tb/tb_io_timer_irq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register offsets, control/status bit positions and timer state type
package io_timer_pkg;
  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_PRESC   = 3'd1;
  localparam logic [2:0] OFS_RLD_LO  = 3'd2;
  localparam logic [2:0] OFS_RLD_HI  = 3'd3;
  localparam logic [2:0] OFS_SNAP    = 3'd4;
  localparam logic [2:0] OFS_SNAP_HI = 3'd5;
  localparam logic [2:0] OFS_CMP     = 3'd6;
  localparam logic [2:0] OFS_STAT    = 3'd7;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_TF   = 0;
  localparam int STAT_OVR  = 1;
  typedef enum logic {IDLE, RUN} timer_state_t;
endpackage

// File: rtl/io_timer_if.sv
// io_timer_if: core port bus (address, write data, write strobe, registered read data)
interface io_timer_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  modport master (output addr, wdata, we, input rdata);
  modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/io_timer_presc.sv
// io_timer_presc: 8-bit prescaler emitting a one-cycle tick every div+1 enabled clocks
module io_timer_presc (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] div_i,
  output logic       tick_o
);
  logic [7:0] cnt_q, cnt_d, div_q, div_d;
  logic       wrap;
  assign wrap   = en_i && cnt_q == div_q;
  assign tick_o = wrap;
  // divisor is sampled only on clear or wrap so a PRESC change never disturbs the running period
  always_comb begin
    cnt_d = clr_i ? 8'd0 : wrap ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
    div_d = (clr_i || wrap) ? div_i : div_q;
  end
  // counter and latched divisor registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      div_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end
endmodule

// File: rtl/io_timer_irq.sv
// io_timer_irq: port-bus 16-bit down-counter timer with irq; optional PWM via IO_TIMER_PWM_EN
module io_timer_irq
  import io_timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR  = 8'h10,
  parameter logic [15:0] RST_RELOAD = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  io_timer_if.slave  io,
  output logic       irq_o,
  output logic       pwm_o
);
  timer_state_t state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] reload_q, reload_d, count_q, count_d, snap_q, snap_d;
  logic        tf_q, tf_d, ovr_q, ovr_d, irq_q;
  logic [7:0]  rdata_q, rd;
  logic        sel, wr, tick, clr, timeout, clr_tf, clr_ovr;
  logic [2:0]  ofs;
`ifdef IO_TIMER_PWM_EN
  logic [7:0]  cmp_q;
  logic        pwm_q;
`endif
  assign sel     = io.addr[7:3] == BASE_ADDR[7:3];
  assign wr      = sel && io.we;
  assign ofs     = io.addr[2:0];
  assign timeout = state_q == RUN && tick && count_q == 16'd0;
  assign clr_tf  = wr && ofs == OFS_STAT && io.wdata[STAT_TF];
  assign clr_ovr = wr && ofs == OFS_STAT && io.wdata[STAT_OVR];
  assign io.rdata = rdata_q;
  assign irq_o    = irq_q;
  io_timer_presc u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr),
    .en_i   (state_q == RUN),
    .div_i  (presc_q),
    .tick_o (tick)
  );
  // timer FSM, counter and register-file next state; bus writes override the timer's own updates
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    count_d  = count_q;
    clr      = 1'b0;
    presc_d  = wr && ofs == OFS_PRESC  ? io.wdata : presc_q;
    reload_d = wr && ofs == OFS_RLD_LO ? {reload_q[15:8], io.wdata} :
               wr && ofs == OFS_RLD_HI ? {io.wdata, reload_q[7:0]} : reload_q;
    snap_d   = wr && ofs == OFS_SNAP ? count_q : snap_q;
    if (state_q == RUN && tick)
      count_d = count_q != 16'd0 ? count_q - 16'd1 : ctrl_q[CTRL_AUTO] ? reload_q : count_q;
    if (timeout && !ctrl_q[CTRL_AUTO]) begin
      ctrl_d[CTRL_EN] = 1'b0;
      state_d = IDLE;
    end
    if (wr && ofs == OFS_CTRL) begin
      ctrl_d  = io.wdata[2:0];
      state_d = io.wdata[CTRL_EN] ? RUN : IDLE;
      clr     = io.wdata[CTRL_EN] && state_q == IDLE;
      count_d = !io.wdata[CTRL_EN] ? count_q : clr ? reload_q : count_d;
    end
    tf_d  = timeout | (tf_q & ~clr_tf);
    ovr_d = (ovr_q & ~clr_ovr) | (timeout & tf_q & ~clr_tf);
  end
  // read mux; anything not addressed returns zero for the OR-combined read bus
  always_comb begin
    rd = 8'h00;
    case (ofs)
      OFS_CTRL:    rd = {5'd0, ctrl_q};
      OFS_PRESC:   rd = presc_q;
      OFS_RLD_LO:  rd = reload_q[7:0];
      OFS_RLD_HI:  rd = reload_q[15:8];
      OFS_SNAP:    rd = snap_q[7:0];
      OFS_SNAP_HI: rd = snap_q[15:8];
`ifdef IO_TIMER_PWM_EN
      OFS_CMP:     rd = cmp_q;
`else
      OFS_CMP:     rd = 8'h00;
`endif
      OFS_STAT:    rd = {6'd0, ovr_q, tf_q};
    endcase
  end
  // state, registers, read data and irq flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ctrl_q   <= 3'd0;
      presc_q  <= 8'd0;
      reload_q <= RST_RELOAD;
      count_q  <= 16'd0;
      snap_q   <= 16'd0;
      tf_q     <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
      tf_q     <= tf_d;
      ovr_q    <= ovr_d;
      irq_q    <= tf_q & ctrl_q[CTRL_IE];
      rdata_q  <= sel ? rd : 8'h00;
    end
  end
`ifdef IO_TIMER_PWM_EN
  // compare register and PWM output, high while the low count byte is below CMP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q <= 8'd0;
      pwm_q <= 1'b0;
    end else begin
      cmp_q <= wr && ofs == OFS_CMP ? io.wdata : cmp_q;
      pwm_q <= ctrl_q[CTRL_EN] && count_q[7:0] < cmp_q;
    end
  end
  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif
endmodule

// File: tb/tb_io_timer_irq.sv
// tb_io_timer_irq: directed table plus hand sequences for timing corner cases of io_timer_irq
module tb_io_timer_irq;
  localparam logic [7:0] B = 8'h10;
`ifdef IO_TIMER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq, pwm;
  int total = 0;
  int bad = 0;
  vec_t tv[20];
  io_timer_if bus();
  io_timer_irq #(.BASE_ADDR(B), .RST_RELOAD(16'hFFFF)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus),
    .irq_o (irq),
    .pwm_o (pwm)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic we, input logic [7:0] a, d, e);
    vec_t v;
    v.we = we;
    v.addr = a;
    v.data = d;
    v.exp = e;
    return v;
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.we = we;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cyc(1'b0, 8'h00, 8'h00);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask
  initial begin
    bus.we = 1'b0;
    bus.addr = 8'h00;
    bus.wdata = 8'h00;
    tv[0]  = mk(1'b0, B + 8'd0, 8'h00, 8'h00);
    tv[1]  = mk(1'b0, B + 8'd1, 8'h00, 8'h00);
    tv[2]  = mk(1'b0, B + 8'd2, 8'h00, 8'hFF);
    tv[3]  = mk(1'b0, B + 8'd3, 8'h00, 8'hFF);
    tv[4]  = mk(1'b0, B + 8'd4, 8'h00, 8'h00);
    tv[5]  = mk(1'b0, B + 8'd5, 8'h00, 8'h00);
    tv[6]  = mk(1'b0, B + 8'd6, 8'h00, 8'h00);
    tv[7]  = mk(1'b0, B + 8'd7, 8'h00, 8'h00);
    tv[8]  = mk(1'b1, B + 8'd1, 8'h5A, 8'h00);
    tv[9]  = mk(1'b0, B + 8'd1, 8'h00, 8'h5A);
    tv[10] = mk(1'b1, B + 8'd2, 8'h34, 8'h00);
    tv[11] = mk(1'b0, B + 8'd2, 8'h00, 8'h34);
    tv[12] = mk(1'b0, B + 8'd3, 8'h00, 8'hFF);
    tv[13] = mk(1'b1, B + 8'd6, 8'h55, 8'h00);
    tv[14] = mk(1'b0, B + 8'd6, 8'h00, PWM ? 8'h55 : 8'h00);
    tv[15] = mk(1'b1, B + 8'd0, 8'hF8, 8'h00);
    tv[16] = mk(1'b0, B + 8'd0, 8'h00, 8'h00);
    tv[17] = mk(1'b0, B + 8'd8, 8'h00, 8'h00);
    tv[18] = mk(1'b1, B + 8'd7, 8'h03, 8'h00);
    tv[19] = mk(1'b0, B + 8'd7, 8'h00, 8'h00);
    do_reset();
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pwm", pwm, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(tv[i].we, tv[i].addr, tv[i].data);
      if (!tv[i].we) chk($sformatf("vec%0d_rd", i), bus.rdata, tv[i].exp);
    end
    chk("tbl_irq", irq, 1'b0);
    chk("tbl_pwm", pwm, 1'b0);
    do_reset();
    cyc(1'b1, B + 8'd2, 8'h03);
    cyc(1'b1, B + 8'd3, 8'h00);
    cyc(1'b1, B + 8'd0, 8'h07);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk($sformatf("auto_irq_low%0d", k), irq, 1'b0);
    end
    idle();
    chk("auto_irq_rise", irq, 1'b1);
    cyc(1'b0, B + 8'd7, 8'h00);
    chk("auto_stat_tf", bus.rdata, 8'h01);
    idle();
    idle();
    cyc(1'b0, B + 8'd7, 8'h00);
    chk("auto_stat_ovr", bus.rdata, 8'h03);
    idle();
    idle();
    cyc(1'b1, B + 8'd7, 8'h01);
    cyc(1'b0, B + 8'd7, 8'h00);
    chk("w1c_race_stat", bus.rdata, 8'h03);
    chk("w1c_race_irq", irq, 1'b1);
    cyc(1'b1, B + 8'd7, 8'h03);
    chk("w1c_irq_lag", irq, 1'b1);
    idle();
    chk("w1c_irq_fall", irq, 1'b0);
    cyc(1'b0, B + 8'd7, 8'h00);
    chk("w1c_stat_clr", bus.rdata, 8'h00);
    idle();
    chk("refire_irq", irq, 1'b1);
    rst = 1'b1;
    cyc(1'b0, B + 8'd7, 8'h00);
    rst = 1'b0;
    chk("midrst_irq", irq, 1'b0);
    cyc(1'b0, B + 8'd7, 8'h00);
    chk("midrst_stat", bus.rdata, 8'h00);
    cyc(1'b0, B + 8'd0, 8'h00);
    chk("midrst_ctrl", bus.rdata, 8'h00);
    do_reset();
    cyc(1'b1, B + 8'd2, 8'h02);
    cyc(1'b1, B + 8'd3, 8'h00);
    cyc(1'b1, B + 8'd1, 8'h01);
    cyc(1'b1, B + 8'd0, 8'h05);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, B + 8'd7, 8'h00);
      chk($sformatf("once_stat%0d", k), bus.rdata, 8'h00);
    end
    cyc(1'b0, B + 8'd7, 8'h00);
    chk("once_stat_tf", bus.rdata, 8'h01);
    chk("once_irq", irq, 1'b1);
    cyc(1'b0, B + 8'd0, 8'h00);
    chk("once_ctrl", bus.rdata, 8'h04);
    cyc(1'b1, B + 8'd4, 8'h00);
    cyc(1'b0, B + 8'd4, 8'h00);
    chk("once_cnt_lo", bus.rdata, 8'h00);
    cyc(1'b0, B + 8'd5, 8'h00);
    chk("once_cnt_hi", bus.rdata, 8'h00);
    do_reset();
    cyc(1'b1, B + 8'd2, 8'h03);
    cyc(1'b1, B + 8'd3, 8'h02);
    cyc(1'b1, B + 8'd0, 8'h01);
    for (int k = 1; k <= 4; k++) idle();
    cyc(1'b1, B + 8'd4, 8'h00);
    cyc(1'b0, B + 8'd4, 8'h00);
    chk("snap_lo", bus.rdata, 8'hFF);
    cyc(1'b0, B + 8'd5, 8'h00);
    chk("snap_hi", bus.rdata, 8'h01);
    cyc(1'b0, B + 8'd8, 8'h00);
    chk("unmapped_b8", bus.rdata, 8'h00);
    cyc(1'b0, 8'hFF, 8'h00);
    chk("unmapped_ff", bus.rdata, 8'h00);
    do_reset();
    cyc(1'b1, B + 8'd6, 8'h02);
    cyc(1'b1, B + 8'd2, 8'h03);
    cyc(1'b1, B + 8'd3, 8'h00);
    cyc(1'b1, B + 8'd0, 8'h03);
    for (int k = 1; k <= 8; k++) begin
      idle();
      chk($sformatf("pwm%0d", k), pwm, PWM && (k % 4 == 3 || k % 4 == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
